// File: rtl/seq_signed_scaler.sv
// seq_signed_scaler
//   Multi-cycle signed fixed-point scaler. Multiplies (sel=0, shift left) or
//   divides (sel=1, arithmetic shift right) a two's-complement word by
//   2^shamt, one bit per clock. Optional saturation on left-shift overflow
//   and round-half-up on right shifts. Valid/ready handshake on both sides.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   in_valid   data_in/shamt/sel valid
//   in_ready   accepting new operand (IDLE only)
//   data_in    signed operand
//   shamt      shift amount, 0..N-1
//   sel        0 = shift left, 1 = arithmetic shift right
//   out_valid  data_out/ovf valid (DONE only)
//   out_ready  consumer accepts result
//   data_out   registered signed result
//   ovf        left-shift overflow, sticky for the operation
//   busy       high in SHIFT or DONE
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one bit shifted per clock, cnt counts down to 1
// DONE  | result presented, waiting for out_ready

module seq_signed_scaler #(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N),
  parameter bit SAT     = 1'b1,
  parameter bit ROUND   = 1'b1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       data_out,
  output logic               ovf,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [N-1:0]       acc, acc_nxt, result;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic               dir, dir_nxt;
  logic               sgn, sgn_nxt;
  logic               rbit, rbit_nxt;
  logic               ovf_nxt;
  logic               live;
  logic               accept;
  logic               load_out;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          if (shamt == '0) begin
            state_nxt = DONE;
            load_out  = 1'b1;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) begin
          state_nxt = DONE;
          load_out  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next datapath values; the result is formed from these so the final
  // shift step and the output load happen on the same edge.
  always_comb begin
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    ovf_nxt  = ovf;
    rbit_nxt = rbit;
    dir_nxt  = dir;
    sgn_nxt  = sgn;
    if (accept) begin
      acc_nxt  = data_in;
      cnt_nxt  = shamt;
      ovf_nxt  = 1'b0;
      rbit_nxt = 1'b0;
      dir_nxt  = sel;
      sgn_nxt  = data_in[N-1];
    end else if (state == SHIFT) begin
      if (!dir) begin
        // Sign changes on this step: a significant bit is lost.
        if (acc[N-1] != acc[N-2]) ovf_nxt = 1'b1;
        acc_nxt = {acc[N-2:0], 1'b0};
      end else begin
        rbit_nxt = acc[0];
        acc_nxt  = {acc[N-1], acc[N-1:1]};
      end
      cnt_nxt = cnt - SHAMT_W'(1);
    end

    result = acc_nxt;
    if (!dir_nxt && SAT && ovf_nxt)
      result = sgn_nxt ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else if (dir_nxt && ROUND)
      result = acc_nxt + {{(N-1){1'b0}}, rbit_nxt};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      rbit     <= 1'b0;
      dir      <= 1'b0;
      sgn      <= 1'b0;
      data_out <= '0;
      live     <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      cnt  <= cnt_nxt;
      ovf  <= ovf_nxt;
      rbit <= rbit_nxt;
      dir  <= dir_nxt;
      sgn  <= sgn_nxt;
      live <= 1'b1;
      if (load_out) data_out <= result;
    end
  end

  // live keeps in_ready low until the first edge after reset release.
  assign in_ready  = (state == IDLE) && live;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_signed_scaler.sv
module tb_seq_signed_scaler;

  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        sel;
  logic        out_ready;

  logic        in_ready,  out_valid,  ovf,  busy;
  logic [31:0] data_out;
  logic        in_ready0, out_valid0, ovf0, busy0;
  logic [31:0] data_out0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_signed_scaler #(.N(32), .SAT(1'b1), .ROUND(1'b1)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shamt(shamt), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .ovf(ovf), .busy(busy)
  );

  seq_signed_scaler #(.N(32), .SAT(1'b0), .ROUND(1'b0)) dut0 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .data_in(data_in), .shamt(shamt), .sel(sel), .out_valid(out_valid0),
    .out_ready(out_ready), .data_out(data_out0), .ovf(ovf0), .busy(busy0)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact arithmetic: x * 2^sh or floor/round of x / 2^sh.
  function automatic void model(input logic [31:0] d, input int sh, input bit sl,
                                input bit sat, input bit rnd,
                                output logic [31:0] r, output bit o);
    longint x, f;
    x = longint'($signed(d));
    o = 1'b0;
    if (!sl) begin
      f = x * (longint'(1) <<< sh);
      o = (f > MAXV) || (f < MINV);
      if (o && sat) r = (x < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
      else          r = f[31:0];
    end else begin
      if (rnd && sh > 0) f = (x + (longint'(1) <<< (sh - 1))) >>> sh;
      else               f = x >>> sh;
      r = f[31:0];
    end
  endfunction

  task automatic do_op(input logic [31:0] d, input int sh, input bit sl, input int stall);
    logic [31:0] e1, e0;
    bit          o1, o0;
    int          cyc, lat;
    model(d, sh, sl, 1'b1, 1'b1, e1, o1);
    model(d, sh, sl, 1'b0, 1'b0, e0, o0);
    data_in  = d;
    shamt    = sh[4:0];
    sel      = sl;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 100) check_val("tmo_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = $urandom;
    shamt    = 5'($urandom);
    sel      = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check_val("latency", 64'(lat), 64'(sh + 1));
    check_val("data_sat_rnd", 64'(data_out), 64'(e1));
    check_val("ovf_sat_rnd", 64'(ovf), 64'(o1));
    check_val("data_wrap_trunc", 64'(data_out0), 64'(e0));
    check_val("ovf_wrap_trunc", 64'(ovf0), 64'(o0));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_val("stall_valid", 64'(out_valid), 64'(1));
      check_val("stall_data", 64'(data_out), 64'(e1));
      check_val("stall_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_valid", 64'(out_valid), 64'(0));
    check_val("post_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    clr       = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    shamt     = '0;
    sel       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data", 64'(data_out), 64'(0));
    check_val("rst_valid", 64'(out_valid), 64'(0));
    check_val("rst_ovf", 64'(ovf), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_in_ready", 64'(in_ready), 64'(0));
    clr = 1'b1;
    #1;
    check_val("rel_in_ready_pre", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    check_val("rel_in_ready", 64'(in_ready), 64'(1));

    do_op(32'h0000_0003, 4, 1'b0, 0);
    do_op(32'hFFFF_FFF8, 2, 1'b1, 1);
    do_op(32'hFFFF_FFF9, 1, 1'b1, 0);
    do_op(32'h4000_0000, 2, 1'b0, 0);
    do_op(32'hC000_0000, 3, 1'b0, 2);
    do_op(32'h0000_0007, 1, 1'b1, 0);
    do_op(32'h7FFF_FFFF, 31, 1'b1, 0);
    do_op(32'h8000_0000, 31, 1'b1, 0);
    do_op(32'h0000_0001, 31, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 31, 1'b0, 0);

    // Stall in DONE with a queued operand.
    data_in  = 32'h89AB_CDEF;
    shamt    = 5'd0;
    sel      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check_val("s0_valid", 64'(out_valid), 64'(1));
    check_val("s0_data", 64'(data_out), 64'h89AB_CDEF);
    data_in = 32'h0000_0123;
    sel     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("s0_hold_valid", 64'(out_valid), 64'(1));
      check_val("s0_hold_data", 64'(data_out), 64'h89AB_CDEF);
      check_val("s0_hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("s0_idle_in_ready", 64'(in_ready), 64'(1));
    check_val("s0_idle_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("s0_queued_valid", 64'(out_valid), 64'(1));
    check_val("s0_queued_data", 64'(data_out), 64'h0000_0123);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Abort by reset in the middle of a long shift.
    data_in  = 32'h0000_0005;
    shamt    = 5'd10;
    sel      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("abort_busy_pre", 64'(busy), 64'(1));
    clr = 1'b0;
    #1;
    check_val("abort_data", 64'(data_out), 64'(0));
    check_val("abort_valid", 64'(out_valid), 64'(0));
    check_val("abort_busy", 64'(busy), 64'(0));
    check_val("abort_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check_val("abort_rel_in_ready", 64'(in_ready), 64'(1));
    do_op(32'h1234_5678, 3, 1'b1, 0);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] rd;
      int          rs;
      bit          rl;
      rd = $urandom;
      rs = int'($urandom_range(0, 31));
      rl = 1'($urandom);
      if (k % 4 == 0) rd = {{20{rd[31]}}, rd[11:0]};
      do_op(rd, rs, rl, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
